register_file: RTL and testbench
================================

# register_file

Architectural register file with rename tags, sitting directly downstream of the reorder buffer's commit port and beside the issue unit. Holds 32 x 32-bit architectural values plus, per register, the ROB index of the youngest in-flight producer. Provides combinational source lookup (value + dependency tag) to the issue unit, records renames at issue, and retires values on ROB commit. Flushes all tags on a misprediction clear.

## Interface
- ROB_WIDTH, 3, ROB index width; index 0 is reserved and means "no dependency" (ROB allocates 1..2**ROB_WIDTH-1)

- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  asynchronous reset, active-low
- rdy_in  input  1  global enable; low freezes all state
- clr_in  input  1  misprediction flush from ROB
- iu_rs1_id  input  5  source register 1 to look up
- rf_rs1_val  output  32  architectural value of rs1 (or bypassed commit value)
- rf_rs1_depend  output  ROB_WIDTH  producer ROB index for rs1, 0 if value is final
- iu_rs2_id  input  5  source register 2 to look up
- rf_rs2_val  output  32  as rs1
- rf_rs2_depend  output  ROB_WIDTH  as rs1
- issue_ready  input  1  an instruction is issued this cycle
- issue_rd_id  input  5  its destination register
- issue_rob_idx  input  ROB_WIDTH  ROB entry allocated to it
- rob_to_rf_ready  input  1  commit valid
- rob_to_rf_reg_id  input  5  committed destination
- rob_to_rf_reg_val  input  32  committed value
- rob_to_rf_rob_idx  input  ROB_WIDTH  ROB entry being committed

## Operation
- State: val[0..31] (32b), depend[0..31] (ROB_WIDTH b). Register 0 is hardwired: val[0]=0, depend[0]=0 always; writes/renames to x0 are ignored.
- Reset (rst_in low, async): all val and depend to 0. Read outputs therefore return 0/0 for every register.
- Lookup (combinational, per source s, independent of rdy_in):
  - default: val=val[s], depend=depend[s].
  - commit bypass: if rob_to_rf_ready && rob_to_rf_reg_id==s && s!=0 && depend[s]!=0 && depend[s]==rob_to_rf_rob_idx, output val=rob_to_rf_reg_val, depend=0.
  - a same-cycle rename of s by issue does not affect the lookup (the issuing instruction's own sources see the pre-rename state).
- Commit (edge, rdy_in high, rob_to_rf_ready, reg_id!=0): val[reg_id] <= reg_val unconditionally. depend[reg_id] <= 0 only if depend[reg_id]==rob_idx and no same-cycle issue rename of the same register; otherwise tag kept (a younger producer still pending).
- Rename (edge, rdy_in high, issue_ready, rd!=0, clr_in low): depend[rd] <= issue_rob_idx. Rename wins over a same-cycle commit clear to the same register.
- Clear (edge, rdy_in high, clr_in high): all depend <= 0; issue rename that cycle is discarded; a commit in the same cycle still writes its value (it is the architecturally retired branch/older instruction).
- rdy_in low: no state change, lookup still active.

## Timing
- Lookup: zero latency, pure combinational from iu_rs*_id, state and commit inputs.
- Rename/commit/clear: take effect at the next rising edge; visible on lookup outputs in the following cycle.
- Commit-to-dependent-issue: 0 cycles via bypass; 1 cycle via stored state.
- Reset asserted mid-operation clears immediately, independent of clock and rdy_in.
- No back-pressure; every valid rename/commit in an enabled cycle is accepted.

## Test plan
- Reset then read x5/x31 -> val 0, depend 0; write commit x0=0xDEADBEEF -> x0 still reads 0/0.
- Issue x3 rob 2; next cycle read x3 -> depend 2; commit x3=0x1234 idx 2 -> same-cycle read val 0x1234 depend 0; next cycle stored 0x1234/0.
- Issue x4 rob 1, then x4 rob 3; commit x4=0x55 idx 1 -> val 0x55 written, depend stays 3.
- Same cycle: commit x6 idx 4 (depend[x6]=4) and issue x6 rob 5 -> next cycle depend[x6]=5, val updated.
- Issue x7 rob 2, x8 rob 3; assert clr_in with commit x9=0x77 and issue x10 rob 4 -> all depend 0, x9=0x77, x10 not renamed.
- rdy_in low with issue/commit active -> no change; drop rst_in mid-cycle -> outputs 0 before next edge.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags: combinational source
// lookup with commit bypass, rename at issue, retire on commit, tag flush on clear.
module register_file #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic [4:0]           iu_rs1_id,
  output logic [31:0]          rf_rs1_val,
  output logic [ROB_WIDTH-1:0] rf_rs1_depend,
  input  logic [4:0]           iu_rs2_id,
  output logic [31:0]          rf_rs2_val,
  output logic [ROB_WIDTH-1:0] rf_rs2_depend,
  input  logic                 issue_ready,
  input  logic [4:0]           issue_rd_id,
  input  logic [ROB_WIDTH-1:0] issue_rob_idx,
  input  logic                 rob_to_rf_ready,
  input  logic [4:0]           rob_to_rf_reg_id,
  input  logic [31:0]          rob_to_rf_reg_val,
  input  logic [ROB_WIDTH-1:0] rob_to_rf_rob_idx
);

  logic [31:0]          val_arr    [32];
  logic [ROB_WIDTH-1:0] depend_arr [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign val_arr[gi]    = '0;
        assign depend_arr[gi] = '0;
      end else begin : g_live
        logic [31:0]          val_reg;
        logic [ROB_WIDTH-1:0] depend_reg;
        logic                 commit_hit;
        logic                 rename_hit;

        assign commit_hit = rob_to_rf_ready && (rob_to_rf_reg_id == 5'(gi));
        assign rename_hit = issue_ready && (issue_rd_id == 5'(gi));

        always_ff @(posedge clk_in or negedge rst_in) begin
          if (!rst_in) begin
            val_reg    <= '0;
            depend_reg <= '0;
          end else if (rdy_in) begin
            if (commit_hit)
              val_reg <= rob_to_rf_reg_val;
            // Flush beats rename; a younger rename beats the commit's tag clear.
            if (clr_in)
              depend_reg <= '0;
            else if (rename_hit)
              depend_reg <= issue_rob_idx;
            else if (commit_hit && depend_reg == rob_to_rf_rob_idx)
              depend_reg <= '0;
          end
        end

        assign val_arr[gi]    = val_reg;
        assign depend_arr[gi] = depend_reg;
      end
    end
  endgenerate

  // Commit bypass applies only when the committing entry is the one the register waits on.
  function automatic logic bypass_hit(input logic [4:0] src);
    return rob_to_rf_ready && (rob_to_rf_reg_id == src) && (src != 5'd0) &&
           (depend_arr[src] != '0) && (depend_arr[src] == rob_to_rf_rob_idx);
  endfunction

  always_comb begin
    rf_rs1_val    = val_arr[iu_rs1_id];
    rf_rs1_depend = depend_arr[iu_rs1_id];
    if (bypass_hit(iu_rs1_id)) begin
      rf_rs1_val    = rob_to_rf_reg_val;
      rf_rs1_depend = '0;
    end
  end

  always_comb begin
    rf_rs2_val    = val_arr[iu_rs2_id];
    rf_rs2_depend = depend_arr[iu_rs2_id];
    if (bypass_hit(iu_rs2_id)) begin
      rf_rs2_val    = rob_to_rf_reg_val;
      rf_rs2_depend = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: inputs change on the falling edge, lookups are
// checked 1ns later, state updates land on the following rising edge.
module tb_register_file;
  localparam int RW = 3;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clr_in;
  logic [4:0]    iu_rs1_id, iu_rs2_id;
  logic [31:0]   rf_rs1_val, rf_rs2_val;
  logic [RW-1:0] rf_rs1_depend, rf_rs2_depend;
  logic          issue_ready;
  logic [4:0]    issue_rd_id;
  logic [RW-1:0] issue_rob_idx;
  logic          rob_to_rf_ready;
  logic [4:0]    rob_to_rf_reg_id;
  logic [31:0]   rob_to_rf_reg_val;
  logic [RW-1:0] rob_to_rf_rob_idx;

  int n_checks = 0;
  int n_fail   = 0;

  register_file #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .iu_rs1_id(iu_rs1_id), .rf_rs1_val(rf_rs1_val), .rf_rs1_depend(rf_rs1_depend),
    .iu_rs2_id(iu_rs2_id), .rf_rs2_val(rf_rs2_val), .rf_rs2_depend(rf_rs2_depend),
    .issue_ready(issue_ready), .issue_rd_id(issue_rd_id), .issue_rob_idx(issue_rob_idx),
    .rob_to_rf_ready(rob_to_rf_ready), .rob_to_rf_reg_id(rob_to_rf_reg_id),
    .rob_to_rf_reg_val(rob_to_rf_reg_val), .rob_to_rf_rob_idx(rob_to_rf_rob_idx)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      $display("check %s: got 0x%08h ok", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Look up two registers and check value/depend of both ports.
  task automatic look(input string tag, input logic [4:0] r1, input logic [31:0] v1,
                      input logic [RW-1:0] d1, input logic [4:0] r2,
                      input logic [31:0] v2, input logic [RW-1:0] d2);
    iu_rs1_id = r1;
    iu_rs2_id = r2;
    #1;
    chk({tag, ".rs1_val"}, rf_rs1_val, v1);
    chk({tag, ".rs1_dep"}, 32'(rf_rs1_depend), 32'(d1));
    chk({tag, ".rs2_val"}, rf_rs2_val, v2);
    chk({tag, ".rs2_dep"}, 32'(rf_rs2_depend), 32'(d2));
  endtask

  task automatic idle();
    issue_ready = 1'b0; rob_to_rf_ready = 1'b0; clr_in = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] idx);
    issue_ready = 1'b1; issue_rd_id = rd; issue_rob_idx = idx;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [RW-1:0] idx);
    rob_to_rf_ready = 1'b1; rob_to_rf_reg_id = rd; rob_to_rf_reg_val = v; rob_to_rf_rob_idx = idx;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    iu_rs1_id = '0; iu_rs2_id = '0;
    issue_ready = 1'b0; issue_rd_id = '0; issue_rob_idx = '0;
    rob_to_rf_ready = 1'b0; rob_to_rf_reg_id = '0; rob_to_rf_reg_val = '0; rob_to_rf_rob_idx = '0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    look("reset", 5'd5, 32'h0, 3'd0, 5'd31, 32'h0, 3'd0);

    // x0 ignores commits
    @(negedge clk_in); commit(5'd0, 32'hDEADBEEF, 3'd1);
    @(negedge clk_in); idle();
    look("x0", 5'd0, 32'h0, 3'd0, 5'd0, 32'h0, 3'd0);

    // rename then same-cycle bypassed commit
    @(negedge clk_in); issue(5'd3, 3'd2);
    @(negedge clk_in); idle();
    look("x3_renamed", 5'd3, 32'h0, 3'd2, 5'd5, 32'h0, 3'd0);
    @(negedge clk_in); commit(5'd3, 32'h1234, 3'd2);
    look("x3_bypass", 5'd3, 32'h1234, 3'd0, 5'd3, 32'h1234, 3'd0);
    @(negedge clk_in); idle();
    look("x3_stored", 5'd3, 32'h1234, 3'd0, 5'd5, 32'h0, 3'd0);

    // older commit retires value but keeps younger tag; no bypass on tag mismatch
    @(negedge clk_in); issue(5'd4, 3'd1);
    @(negedge clk_in); issue(5'd4, 3'd3);
    @(negedge clk_in); idle(); commit(5'd4, 32'h55, 3'd1);
    look("x4_nobypass", 5'd4, 32'h0, 3'd3, 5'd3, 32'h1234, 3'd0);
    @(negedge clk_in); idle();
    look("x4_kept", 5'd4, 32'h55, 3'd3, 5'd0, 32'h0, 3'd0);

    // commit and rename to same register in one cycle
    @(negedge clk_in); issue(5'd6, 3'd4);
    @(negedge clk_in); idle(); commit(5'd6, 32'h66, 3'd4); issue(5'd6, 3'd5);
    look("x6_bypass_pre", 5'd6, 32'h66, 3'd0, 5'd6, 32'h66, 3'd0);
    @(negedge clk_in); idle();
    look("x6_rename_wins", 5'd6, 32'h66, 3'd5, 5'd4, 32'h55, 3'd3);

    // misprediction clear with commit and discarded rename
    @(negedge clk_in); issue(5'd7, 3'd2);
    @(negedge clk_in); issue(5'd8, 3'd3);
    @(negedge clk_in); idle(); clr_in = 1'b1; commit(5'd9, 32'h77, 3'd6); issue(5'd10, 3'd4);
    @(negedge clk_in); idle();
    look("clr_a", 5'd7, 32'h0, 3'd0, 5'd8, 32'h0, 3'd0);
    look("clr_b", 5'd9, 32'h77, 3'd0, 5'd10, 32'h0, 3'd0);
    look("clr_c", 5'd6, 32'h66, 3'd0, 5'd4, 32'h55, 3'd0);

    // rdy_in low freezes state
    @(negedge clk_in); rdy_in = 1'b0; issue(5'd11, 3'd5); commit(5'd12, 32'h99, 3'd1); clr_in = 1'b0;
    @(negedge clk_in); idle(); rdy_in = 1'b1;
    look("frozen", 5'd11, 32'h0, 3'd0, 5'd12, 32'h0, 3'd0);

    // async reset mid-cycle
    @(negedge clk_in); issue(5'd13, 3'd6);
    @(negedge clk_in); idle();
    look("pre_rst", 5'd4, 32'h55, 3'd0, 5'd13, 32'h0, 3'd6);
    @(posedge clk_in); #2;
    rst_in = 1'b0;
    look("async_rst", 5'd4, 32'h0, 3'd0, 5'd13, 32'h0, 3'd0);
    @(negedge clk_in); rst_in = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
